// File: rtl/io_bus_pkg.sv
// Shared definitions for the core's memory-mapped IO bus: access sizes,
// bus-master state encoding, board IO address map and the legality check.
package io_bus_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int unsigned IO_SW  = 1;
  localparam int unsigned IO_BTN = 2;
  localparam int unsigned IO_LED = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Unsigned sizes only exist for loads; H/HU need half alignment, W full.
  function automatic logic access_legal(input logic wr, input logic [2:0] size,
                                        input logic [1:0] a);
    case (size)
      SZ_B:    return 1'b1;
      SZ_BU:   return !wr;
      SZ_H:    return !a[0];
      SZ_HU:   return !wr && !a[0];
      SZ_W:    return a == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/io_load_extend.sv
// Combinational RV32 load extension of right-aligned data, selected by funct3.
module io_load_extend
  import io_bus_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_B:    ext = {{24{raw[7]}}, raw[7:0]};
      SZ_BU:   ext = {24'h0, raw[7:0]};
      SZ_H:    ext = {{16{raw[15]}}, raw[15:0]};
      SZ_HU:   ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/io_bus_master.sv
// IO bus initiator: one load/store at a time, single-cycle enable pulses,
// fixed read latency, extended load data and rejection of illegal accesses.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_size,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] io_address,
  output logic [31:0]       io_write_value,
  input  logic [31:0]       io_read_value,
  output logic              io_write_en,
  output logic              io_read_en,
  output logic [2:0]        io_data_size
);

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] io_address_q, io_address_d;
  logic [31:0]       io_write_value_q, io_write_value_d;
  logic [2:0]        io_data_size_q, io_data_size_d;
  logic              io_write_en_q, io_write_en_d;
  logic              io_read_en_q, io_read_en_d;
  logic              write_q, write_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       load_ext;

  io_load_extend u_ext (
    .size (io_data_size_q),
    .raw  (io_read_value),
    .ext  (load_ext)
  );

  // Bus-facing registers are loaded at accept so the ISSUE cycle already
  // presents them; rejected requests leave the bus untouched.
  always_comb begin
    state_d          = state_q;
    resp_valid_d     = 1'b0;
    resp_err_d       = 1'b0;
    resp_rdata_d     = resp_rdata_q;
    io_address_d     = io_address_q;
    io_write_value_d = io_write_value_q;
    io_data_size_d   = io_data_size_q;
    io_write_en_d    = 1'b0;
    io_read_en_d     = 1'b0;
    write_d          = write_q;
    cnt_d            = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (access_legal(req_write, req_size, req_addr[1:0])) begin
            io_address_d     = req_addr;
            io_write_value_d = req_wdata;
            io_data_size_d   = req_size;
            write_d          = req_write;
            io_write_en_d    = req_write;
            io_read_en_d     = !req_write;
            state_d          = ST_ISSUE;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (write_q) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          state_d      = ST_RESP;
        end else begin
          cnt_d   = 4'(READ_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext;
          state_d      = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= '0;
      io_address_q     <= '0;
      io_write_value_q <= '0;
      io_data_size_q   <= '0;
      io_write_en_q    <= 1'b0;
      io_read_en_q     <= 1'b0;
      write_q          <= 1'b0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      io_address_q     <= io_address_d;
      io_write_value_q <= io_write_value_d;
      io_data_size_q   <= io_data_size_d;
      io_write_en_q    <= io_write_en_d;
      io_read_en_q     <= io_read_en_d;
      write_q          <= write_d;
      cnt_q            <= cnt_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign io_address     = io_address_q;
  assign io_write_value = io_write_value_q;
  assign io_data_size   = io_data_size_q;
  assign io_write_en    = io_write_en_q;
  assign io_read_en     = io_read_en_q;

endmodule
